// File: rtl/bus_source_arbiter.sv
// -----------------------------------------------------------------------------
// bus_source_arbiter
//
// Purpose:
//   Sits between the control unit and the 32-to-5 bus-source encoder. A
//   multi-bit register-out request is captured once and replayed as a series
//   of one-hot (or all-zero) grant vectors. Each grant is held for HOLD
//   cycles, so the encoder only ever sees a legal single-source select.
//
// Parameters:
//   N_SRC  number of legal bus sources; bits [N_SRC-1:0] are grantable,
//          bits [31:N_SRC] are illegal and are reported via err_range.
//   HOLD   cycles each grant stays on the bus (1..15).
//
// Optional feature (macro BUS_ARB_ROUND_ROBIN_EN):
//   Defined   - each pick is the lowest pending bit strictly above the index
//               of the previous grant, wrapping to bit 0. The last-granted
//               index persists across sequences and resets to N_SRC-1.
//   Undefined - fixed lowest-index-first priority.
//
// Ports:
//   clk          rising-edge clock
//   clr_n        asynchronous active-low reset
//   req_valid    request vector present this cycle
//   req[31:0]    register-out request bits, any number may be set
//   ready        arbiter idle and able to accept req
//   flush        synchronous abort of pending and current grants
//   err_clr      synchronous clear of the sticky error flags
//   grant[31:0]  one-hot bus-source select, or zero
//   grant_valid  OR of grant
//   grant_last   final cycle of the final grant of the sequence
//   err_range    sticky: an accepted request carried bits >= N_SRC
//   err_ovr      sticky: req_valid seen while ready was low
//   state_dbg    current FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a request is accepted at a rising edge where req_valid=1,
// ready=1 and flush=0. req_valid while ready=0 is dropped and flagged in
// err_ovr; the request is not retried, the source must re-present it.
// -----------------------------------------------------------------------------
module bus_source_arbiter #(
    parameter int N_SRC = 24,
    parameter int HOLD  = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        req_valid,
    input  logic [31:0] req,
    output logic        ready,
    input  logic        flush,
    input  logic        err_clr,
    output logic [31:0] grant,
    output logic        grant_valid,
    output logic        grant_last,
    output logic        err_range,
    output logic        err_ovr,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Mask of grantable sources, built bit by bit so N_SRC=32 needs no
    // special-case shift.
    function automatic logic [31:0] legal_mask_f();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < N_SRC);
        end
        return m;
    endfunction

    localparam logic [31:0] LEGAL_MASK = legal_mask_f();
    localparam logic [3:0]  HOLD_M1    = 4'(HOLD - 1);

`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam logic [4:0]  LAST_RST   = 5'(N_SRC - 1);

    // Lowest set bit strictly above 'after'; if none, wrap to the lowest
    // set bit overall. Scanning downward lets the last hit be the lowest.
    function automatic logic [4:0] pick_idx(input logic [31:0] v,
                                            input logic [4:0]  after);
        logic [4:0] lo;
        logic [4:0] hi;
        logic       hi_found;
        lo       = '0;
        hi       = '0;
        hi_found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                lo = 5'(i);
                if (5'(i) > after) begin
                    hi       = 5'(i);
                    hi_found = 1'b1;
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction
`else
    // Lowest set bit; downward scan so the final hit is the lowest index.
    function automatic logic [4:0] pick_idx(input logic [31:0] v);
        logic [4:0] lo;
        lo = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                lo = 5'(i);
            end
        end
        return lo;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] grant_q, grant_d;
    logic [3:0]  hold_q, hold_d;
    logic        err_range_q, err_range_d;
    logic        err_ovr_q, err_ovr_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [4:0]  last_q, last_d;
`endif

    logic        accept;
    logic [31:0] masked_req;
    logic [31:0] sel_src;
    logic [4:0]  sel_idx;
    logic [31:0] sel_onehot;

    assign accept     = req_valid && (state_q == IDLE) && !flush;
    assign masked_req = req & LEGAL_MASK;

    // In IDLE the candidate set is the incoming request; in GRANT it is
    // whatever is left in pending. Only one of them is ever used per cycle.
    assign sel_src    = (state_q == IDLE) ? masked_req : pending_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    assign sel_idx    = pick_idx(sel_src, last_q);
`else
    assign sel_idx    = pick_idx(sel_src);
`endif
    assign sel_onehot = 32'd1 << sel_idx;

    // Next-state and datapath.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
            grant_d   = '0;
            hold_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A fully masked-off request leaves the arbiter idle.
                    if (accept && (masked_req != '0)) begin
                        grant_d   = sel_onehot;
                        pending_d = masked_req & ~sel_onehot;
                        hold_d    = HOLD_M1;
                        state_d   = GRANT;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                        last_d    = sel_idx;
`endif
                    end
                end
                GRANT: begin
                    if (hold_q != 4'd0) begin
                        hold_d = hold_q - 4'd1;
                    end else if (pending_q != '0) begin
                        // Back-to-back hand-over: no zero cycle between grants.
                        grant_d   = sel_onehot;
                        pending_d = pending_q & ~sel_onehot;
                        hold_d    = HOLD_M1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                        last_d    = sel_idx;
`endif
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    pending_d = '0;
                    grant_d   = '0;
                    hold_d    = '0;
                end
            endcase
        end
    end

    // Sticky errors: a set on the same edge as err_clr wins. A req_valid
    // swallowed by flush is neither accepted nor counted as an overrun.
    always_comb begin
        err_range_d = err_range_q & ~err_clr;
        err_ovr_d   = err_ovr_q & ~err_clr;
        if (accept && ((req & ~LEGAL_MASK) != '0)) begin
            err_range_d = 1'b1;
        end
        if (req_valid && (state_q == GRANT) && !flush) begin
            err_ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            grant_q     <= '0;
            hold_q      <= '0;
            err_range_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            grant_q     <= grant_d;
            hold_q      <= hold_d;
            err_range_q <= err_range_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

`ifdef BUS_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_q <= LAST_RST;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign ready       = (state_q == IDLE);
    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_last  = (state_q == GRANT) && (hold_q == 4'd0) && (pending_q == '0);
    assign err_range   = err_range_q;
    assign err_ovr     = err_ovr_q;
    assign state_dbg   = (state_q == GRANT);

endmodule
